magma_bus_arbiter: RTL and testbench
====================================

// Module: magma_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one slave bus (shared RAM / IO fabric) among NUM_MASTERS
//  requesters: CPU instr port, CPU data port, udm debug master. Sits between the masters and
//  the slave port. Carries one transaction at a time: select, forward the request, wait for
//  ack (and read resp), release. Uses the same req/ack/resp protocol as the rest of the SoC.
// PARAMETERS
//  NUM_MASTERS  3      number of requesters, 2..8; index 0 = highest priority at reset
//  ADDR_W       32     address width
//  DATA_W       32     data width; be width = DATA_W/8
//  TIMEOUT      1023   watchdog limit in cycles (only with MAGMA_ARB_TIMEOUT_EN)
// PORTS
//  clk_i        in   1                 clock
//  arst_n_i     in   1                 reset, asynchronous, active-low
//  m_req_i      in   NUM_MASTERS       per-master request
//  m_we_i       in   NUM_MASTERS       per-master write enable
//  m_addr_i     in   NUM_MASTERS*ADDR_W  flattened addresses, master k at [k*ADDR_W +: ADDR_W]
//  m_be_i       in   NUM_MASTERS*DATA_W/8 flattened byte enables
//  m_wdata_i    in   NUM_MASTERS*DATA_W flattened write data
//  m_ack_o      out  NUM_MASTERS       one-hot request accepted
//  m_resp_o     out  NUM_MASTERS       one-hot read data valid
//  m_rdata_o    out  DATA_W            read data, shared by all masters
//  s_req_o      out  1                 slave request
//  s_we_o       out  1                 slave write enable
//  s_addr_o     out  ADDR_W            slave address
//  s_be_o       out  DATA_W/8          slave byte enables
//  s_wdata_o    out  DATA_W            slave write data
//  s_ack_i      in   1                 slave accepted request
//  s_resp_i     in   1                 slave read data valid
//  s_rdata_i    in   DATA_W            slave read data
// BEHAVIOUR
//  - Reset (arst_n_i=0, any state, takes effect at once): FSM=IDLE, grant=0, rr_ptr=0, every
//    output 0. An in-flight transaction is dropped with no ack/resp. Slave-side recovery is the
//    system reset's job.
//  - FSM IDLE: if any m_req_i is set, register grant = first requester at or after rr_ptr
//    (cyclic search) and latch its we/addr/be/wdata. Go to REQ. No requests: stay in IDLE.
//  - REQ: s_req_o=1 with the latched fields. Master request lines are ignored here.
//    On s_ack_i: m_ack_o[grant]=1 in the same cycle (combinational), rr_ptr<=(grant+1)%NUM_MASTERS.
//    Then go to IDLE if the access was a write, or to RESP if it was a read.
//  - RESP: s_req_o=0. On s_resp_i: m_resp_o[grant]=1 and m_rdata_o=s_rdata_i in the same
//    cycle, then go to IDLE. s_resp_i in IDLE or REQ is ignored.
//  - Grant-to-slave latency: the first s_req_o comes 1 cycle after m_req_i is seen in IDLE.
//    Minimum occupancy is 2 cycles per write and 3 per read (a 1-cycle idle gap between
//    transactions is accepted).
//  - A master holds req and its fields stable until its m_ack_o. Dropping req before ack is a
//    protocol violation; the arbiter still completes the latched transaction.
//  - Fairness: after a grant, the granted master has lowest priority. With all masters
//    requesting, the grant order is 0,1,..,N-1,0,... No master waits more than NUM_MASTERS-1
//    transactions.
//  - rr_ptr wraps from NUM_MASTERS-1 to 0. m_ack_o and m_resp_o are never multi-hot.
//  - m_rdata_o=s_rdata_i while in RESP, otherwise 0.
// CONFIGURATION
//  MAGMA_ARB_TIMEOUT_EN defined:
//  - A cycle counter clears on entry to REQ or RESP and counts while in either state.
//  - When it reaches TIMEOUT without s_ack_i (REQ) or s_resp_i (RESP), the arbiter
//    force-completes: m_ack_o[grant]=1 (REQ; for a read also m_resp_o[grant]=1 with
//    m_rdata_o=32'hDEADBEEF), or m_resp_o[grant]=1 with m_rdata_o=32'hDEADBEEF (RESP).
//    It then returns to IDLE and advances rr_ptr. A sticky bit is set and cleared only by reset.
//  - Extra output: timeout_o  out  1  sticky timeout flag, reset 0.
//  MAGMA_ARB_TIMEOUT_EN undefined: no counter, no timeout_o port; the arbiter waits
//  indefinitely in REQ/RESP.
// TESTING
//  T1 single write: m0 req, we=1, addr=32'h0, wdata=32'h123455aa, slave acks after 2 cycles
//     -> s_addr_o=0, s_wdata_o=32'h123455aa, m_ack_o=3'b001 once, FSM back to IDLE.
//  T2 single read: m2 (udm) reads 32'h80000004, slave resp 32'h5aaa5aaa 3 cycles after ack
//     -> m_ack_o=3'b100, then m_resp_o=3'b100 with m_rdata_o=32'h5aaa5aaa.
//  T3 contention: m0,m1,m2 all request writes continuously, slave acks immediately
//     -> grant sequence 0,1,2,0,1,2; 6 acks in 12 cycles; never two acks in one cycle.
//  T4 fairness: m0 requests continuously, m2 requests once -> m2 is granted within 2
//     transactions; m0 does not win twice in a row while m2 is waiting.
//  T5 reset mid-read: arst_n_i low while in RESP -> all outputs 0 immediately; after release
//     a new m1 read is granted first (rr_ptr=0, m0 idle) and completes normally.
//  T6 (MAGMA_ARB_TIMEOUT_EN, TIMEOUT=15) slave never acks m1's read -> after 15 cycles
//     m_ack_o=m_resp_o=3'b010, m_rdata_o=32'hDEADBEEF, timeout_o=1 and stays 1.

Source files
------------

// File: rtl/magma_bus_arbiter.sv
// Round-robin arbiter that carries one master transaction at a time onto a shared slave bus.
// Define MAGMA_ARB_TIMEOUT_EN to add the REQ/RESP watchdog, the TIMEOUT parameter and timeout_o.
module magma_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
`ifdef MAGMA_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 1023
`endif
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic [NUM_MASTERS-1:0]          m_req_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_resp_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_req_o,
    output logic                            s_we_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W/8-1:0]             s_be_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    input  logic                            s_ack_i,
    input  logic                            s_resp_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic [1:0]                      o_dbg_state
`ifdef MAGMA_ARB_TIMEOUT_EN
    ,
    output logic                            timeout_o
`endif
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     w_sel;
    logic [GW-1:0]     w_grant_inc;
    logic [GW:0]       w_sum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              w_adv;

    // Handshake: a master holds m_req_i and its fields until its one-cycle m_ack_o pulse; the
    // slave pulses s_ack_i to accept s_req_o and later pulses s_resp_i with s_rdata_i for reads.

`ifdef MAGMA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    logic          w_expired;
    logic          w_force;

    assign w_expired = (r_state != S_IDLE) && (r_cnt == CW'(TIMEOUT));
    assign timeout_o = r_timeout;
`endif

    assign o_dbg_state = r_state;
    assign w_grant_inc = (r_grant == GW'(NUM_MASTERS - 1)) ? '0 : r_grant + GW'(1);

    // Walk the ring backwards so the requester closest to r_rr_ptr is the last one assigned.
    always_comb begin
        w_sel = r_rr_ptr;
        w_sum = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (w_sum >= (GW+1)'(NUM_MASTERS))
                w_sum = w_sum - (GW+1)'(NUM_MASTERS);
            if (m_req_i[w_sum[GW-1:0]])
                w_sel = w_sum[GW-1:0];
        end
    end

    always_comb begin
        w_next    = r_state;
        w_adv     = 1'b0;
        m_ack_o   = '0;
        m_resp_o  = '0;
        m_rdata_o = '0;
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
`ifdef MAGMA_ARB_TIMEOUT_EN
        w_force   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|m_req_i)
                    w_next = S_REQ;
            end
            S_REQ: begin
                s_req_o   = 1'b1;
                s_we_o    = r_we;
                s_addr_o  = r_addr;
                s_be_o    = r_be;
                s_wdata_o = r_wdata;
                if (s_ack_i) begin
                    m_ack_o[r_grant] = 1'b1;
                    w_adv            = 1'b1;
                    w_next           = r_we ? S_IDLE : S_RESP;
                end
`ifdef MAGMA_ARB_TIMEOUT_EN
                else if (w_expired) begin
                    m_ack_o[r_grant] = 1'b1;
                    w_adv            = 1'b1;
                    w_force          = 1'b1;
                    w_next           = S_IDLE;
                    if (!r_we) begin
                        m_resp_o[r_grant] = 1'b1;
                        m_rdata_o         = DATA_W'(32'hDEADBEEF);
                    end
                end
`endif
            end
            S_RESP: begin
                m_rdata_o = s_rdata_i;
                if (s_resp_i) begin
                    m_resp_o[r_grant] = 1'b1;
                    w_next            = S_IDLE;
                end
`ifdef MAGMA_ARB_TIMEOUT_EN
                else if (w_expired) begin
                    m_resp_o[r_grant] = 1'b1;
                    m_rdata_o         = DATA_W'(32'hDEADBEEF);
                    w_adv             = 1'b1;
                    w_force           = 1'b1;
                    w_next            = S_IDLE;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else begin
            if (r_state == S_IDLE && |m_req_i) begin
                r_grant <= w_sel;
                r_we    <= m_we_i[w_sel];
                r_addr  <= m_addr_i[int'(w_sel) * ADDR_W +: ADDR_W];
                r_be    <= m_be_i[int'(w_sel) * BE_W +: BE_W];
                r_wdata <= m_wdata_i[int'(w_sel) * DATA_W +: DATA_W];
            end
            if (w_adv)
                r_rr_ptr <= w_grant_inc;
        end
    end

`ifdef MAGMA_ARB_TIMEOUT_EN
    // The counter restarts whenever the state changes, so REQ and RESP each get a full budget.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_next != r_state)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (w_force)
                r_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_magma_bus_arbiter.sv
// Self-checking bench for magma_bus_arbiter: directed vector table, corner sequences, random run.
`timescale 1ns/1ps
module tb_magma_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    m_req = '0, m_we = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*BW-1:0] m_be = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_ack, m_resp;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_we;
  logic [AW-1:0]   s_addr;
  logic [BW-1:0]   s_be;
  logic [DW-1:0]   s_wdata;
  logic            s_ack = 1'b0, s_resp = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      dbg_state;
`ifdef MAGMA_ARB_TIMEOUT_EN
  logic            timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  req;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    int            ack_dly;
    int            resp_dly;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_grant;
  } vec_t;
  vec_t vecs[11];

  magma_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef MAGMA_ARB_TIMEOUT_EN
    , .TIMEOUT(15)
`endif
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
    .o_dbg_state(dbg_state)
`ifdef MAGMA_ARB_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    m_req[k] = req;
    m_we[k] = we;
    m_addr[k*AW +: AW] = addr;
    m_be[k*BW +: BW] = be;
    m_wdata[k*DW +: DW] = wdata;
  endtask

  task automatic apply_reset();
    arst_n = 1'b0;
    m_req = '0;
    s_ack = 1'b0;
    s_resp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    next_cycle();
    for (int k = 0; k < N; k++) begin
      if (!v.req[k]) set_master(k, 1'b0, 1'b0, '0, '0, '0);
      else if (v.exp_grant[k]) set_master(k, 1'b1, v.we, v.addr, v.be, v.wdata);
      else set_master(k, 1'b1, ~v.we, ~v.addr, ~v.be, ~v.wdata);
    end
    s_ack = 1'b0;
    s_resp = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_idle_state", idx), dbg_state, 2'd0);
    check($sformatf("vec%0d_idle_s_req", idx), s_req, 1'b0);
    for (int d = 0; d <= v.ack_dly; d++) begin
      next_cycle();
      s_ack = (d == v.ack_dly);
      @(negedge clk);
      check($sformatf("vec%0d_s_req", idx), s_req, 1'b1);
      check($sformatf("vec%0d_s_we", idx), s_we, v.we);
      check($sformatf("vec%0d_s_addr", idx), s_addr, v.addr);
      check($sformatf("vec%0d_s_be", idx), s_be, v.be);
      check($sformatf("vec%0d_s_wdata", idx), s_wdata, v.wdata);
      check($sformatf("vec%0d_m_ack", idx), m_ack, (d == v.ack_dly) ? v.exp_grant : '0);
      check($sformatf("vec%0d_m_resp_in_req", idx), m_resp, '0);
    end
    next_cycle();
    s_ack = 1'b0;
    m_req = '0;
    if (!v.we) begin
      for (int d = 0; d <= v.resp_dly; d++) begin
        if (d > 0) next_cycle();
        s_resp = (d == v.resp_dly);
        s_rdata = (d == v.resp_dly) ? v.rdata : $urandom;
        @(negedge clk);
        check($sformatf("vec%0d_resp_state", idx), dbg_state, 2'd2);
        check($sformatf("vec%0d_resp_s_req", idx), s_req, 1'b0);
        check($sformatf("vec%0d_m_resp", idx), m_resp, (d == v.resp_dly) ? v.exp_grant : '0);
        check($sformatf("vec%0d_m_rdata", idx), m_rdata, s_rdata);
      end
      next_cycle();
      s_resp = 1'b0;
    end
  endtask

  // Reference model: free / awaiting-ack / awaiting-resp, grant = first requester from ptr.
  task automatic random_phase(input int cycles);
    int ptr, owner, max_wait;
    bit busy, wait_resp;
    int waits[N];
    logic [N-1:0] exp_ack, exp_resp, done;
    logic [DW-1:0] exp_rdata;
    ptr = 0; owner = 0; max_wait = 0; busy = 0; wait_resp = 0; done = '0;
    foreach (waits[k]) waits[k] = 0;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        if (done[k]) m_req[k] = 1'b0;
        if (!m_req[k] && $urandom_range(0, 2) == 0)
          set_master(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, BW'($urandom), $urandom);
      end
      s_ack = ($urandom_range(0, 3) != 0);
      s_resp = ($urandom_range(0, 3) != 0);
      s_rdata = $urandom;
      @(negedge clk);
      exp_ack = '0; exp_resp = '0; exp_rdata = '0;
      check("rnd_s_req", s_req, busy && !wait_resp);
      if (busy && !wait_resp) begin
        check("rnd_s_we", s_we, m_we[owner]);
        check("rnd_s_addr", s_addr, m_addr[owner*AW +: AW]);
        check("rnd_s_be", s_be, m_be[owner*BW +: BW]);
        check("rnd_s_wdata", s_wdata, m_wdata[owner*DW +: DW]);
        if (s_ack) begin
          exp_ack[owner] = 1'b1;
          for (int k = 0; k < N; k++)
            if (k != owner && m_req[k]) begin
              waits[k]++;
              if (waits[k] > max_wait) max_wait = waits[k];
            end
          waits[owner] = 0;
          ptr = (owner + 1) % N;
          if (m_we[owner]) busy = 0;
          else wait_resp = 1;
        end
      end else if (busy) begin
        exp_rdata = s_rdata;
        if (s_resp) begin
          exp_resp[owner] = 1'b1;
          busy = 0;
          wait_resp = 0;
        end
      end else if (m_req != '0) begin
        for (int i = 0; i < N; i++) begin
          int cand;
          cand = (ptr + i) % N;
          if (m_req[cand]) begin
            owner = cand;
            break;
          end
        end
        busy = 1;
      end
      check("rnd_m_ack", m_ack, exp_ack);
      check("rnd_m_resp", m_resp, exp_resp);
      check("rnd_m_rdata", m_rdata, exp_rdata);
      done = exp_ack;
    end
    check("rnd_fair_max_wait_within_n_minus_1", (max_wait <= N - 1), 1'b1);
    next_cycle();
    m_req = '0; s_ack = 1'b0; s_resp = 1'b0;
  endtask

  initial begin
    int n_ack;
    logic [N-1:0] last_ack;
    vecs[0]  = '{3'b001, 1'b1, 32'h0000_0000, 4'hf, 32'h1234_55aa, 2, 0, 32'h0, 3'b001};
    vecs[1]  = '{3'b100, 1'b0, 32'h8000_0004, 4'hf, 32'h0, 0, 3, 32'h5aaa_5aaa, 3'b100};
    vecs[2]  = '{3'b110, 1'b1, 32'h0000_0010, 4'h3, 32'ha5a5_a5a5, 1, 0, 32'h0, 3'b010};
    vecs[3]  = '{3'b011, 1'b0, 32'h0000_0020, 4'hf, 32'h0, 0, 0, 32'h0000_ffff, 3'b001};
    vecs[4]  = '{3'b111, 1'b1, 32'h0000_0040, 4'hc, 32'hdead_f00d, 0, 0, 32'h0, 3'b010};
    vecs[5]  = '{3'b111, 1'b0, 32'h0000_0044, 4'hf, 32'h0, 1, 1, 32'h1234_5678, 3'b100};
    vecs[6]  = '{3'b101, 1'b1, 32'h0000_0048, 4'h1, 32'hffff_ffff, 3, 0, 32'h0, 3'b001};
    vecs[7]  = '{3'b101, 1'b0, 32'h0000_004c, 4'hf, 32'h0, 2, 2, 32'h8765_4321, 3'b100};
    vecs[8]  = '{3'b010, 1'b1, 32'hffff_fffc, 4'hf, 32'h0000_0000, 0, 0, 32'h0, 3'b010};
    vecs[9]  = '{3'b100, 1'b0, 32'h0000_0050, 4'hf, 32'h0, 0, 0, 32'hcafe_babe, 3'b100};
    vecs[10] = '{3'b011, 1'b1, 32'h0000_0054, 4'h6, 32'h0f0f_0f0f, 1, 0, 32'h0, 3'b001};

    // reset state, with every input pushing
    m_req = '1; s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h1357_9bdf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_req", s_req, 1'b0);
    check("rst_m_ack", m_ack, '0);
    check("rst_m_resp", m_resp, '0);
    check("rst_m_rdata", m_rdata, '0);
    check("rst_s_addr", s_addr, '0);
    check("rst_state", dbg_state, 2'd0);
    next_cycle();
    arst_n = 1'b1; m_req = '0; s_ack = 1'b0; s_resp = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // contention: all masters write continuously, slave acks at once
    apply_reset();
    next_cycle();
    for (int k = 0; k < N; k++) set_master(k, 1'b1, 1'b1, 32'h100 * k, 4'hf, $urandom);
    s_ack = 1'b1;
    exp_q = {3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      check("t3_ack_not_multihot", ($countones(m_ack) <= 1), 1'b1);
      if (m_ack != '0) begin
        n_ack++;
        if (exp_q.size() > 0) check("t3_grant_order", m_ack, exp_q.pop_front());
        else check("t3_extra_ack", m_ack, '0);
      end
    end
    check("t3_ack_count", n_ack, 6);
    check("t3_queue_drained", exp_q.size(), 0);
    next_cycle();
    m_req = '0; s_ack = 1'b0;

    // fairness: m0 always requests, m2 requests once
    next_cycle();
    set_master(0, 1'b1, 1'b1, 32'ha0, 4'hf, $urandom);
    set_master(2, 1'b1, 1'b1, 32'ha8, 4'hf, $urandom);
    s_ack = 1'b1;
    exp_q = {3'b001, 3'b100, 3'b001, 3'b001};
    n_ack = 0;
    last_ack = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        next_cycle();
        if (last_ack[2]) m_req[2] = 1'b0;
      end
      @(negedge clk);
      last_ack = m_ack;
      if (m_ack != '0) begin
        n_ack++;
        if (exp_q.size() > 0) check("t4_grant_order", m_ack, exp_q.pop_front());
        else check("t4_extra_ack", m_ack, '0);
      end
    end
    check("t4_ack_count", n_ack, 4);
    check("t4_queue_drained", exp_q.size(), 0);
    next_cycle();
    m_req = '0; s_ack = 1'b0;

    // reset in the middle of a read
    apply_reset();
    next_cycle();
    set_master(1, 1'b1, 1'b0, 32'h2000, 4'hf, '0);
    @(negedge clk);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    check("t5_pre_ack", m_ack, 3'b010);
    next_cycle();
    s_ack = 1'b0; m_req = '0;
    @(negedge clk);
    check("t5_in_resp", dbg_state, 2'd2);
    #2;
    arst_n = 1'b0; s_resp = 1'b1; s_rdata = 32'h1111_2222; m_req = '1;
    #1;
    check("t5_rst_state", dbg_state, 2'd0);
    check("t5_rst_m_resp", m_resp, '0);
    check("t5_rst_m_rdata", m_rdata, '0);
    check("t5_rst_s_req", s_req, 1'b0);
    check("t5_rst_m_ack", m_ack, '0);
    @(posedge clk);
    #1;
    arst_n = 1'b1; m_req = '0; s_resp = 1'b0;
    next_cycle();
    set_master(1, 1'b1, 1'b0, 32'h3000, 4'hf, '0);
    set_master(2, 1'b1, 1'b0, 32'h4000, 4'hf, '0);
    @(negedge clk);
    check("t5_idle_s_req", s_req, 1'b0);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    check("t5_grant_m1", m_ack, 3'b010);
    check("t5_s_addr", s_addr, 32'h3000);
    next_cycle();
    s_ack = 1'b0; m_req = '0; s_resp = 1'b1; s_rdata = 32'h0bad_cafe;
    @(negedge clk);
    check("t5_m_resp", m_resp, 3'b010);
    check("t5_m_rdata", m_rdata, 32'h0bad_cafe);
    next_cycle();
    s_resp = 1'b0;
    @(negedge clk);
    check("t5_back_idle", dbg_state, 2'd0);

`ifdef MAGMA_ARB_TIMEOUT_EN
    begin
      int c6;
      apply_reset();
      next_cycle();
      set_master(1, 1'b1, 1'b0, 32'h5000, 4'hf, '0);
      for (c6 = 0; c6 < 40; c6++) begin
        @(negedge clk);
        if (m_ack != '0) break;
        next_cycle();
      end
      check("t6_fire_cycle", c6, 16);
      check("t6_m_ack", m_ack, 3'b010);
      check("t6_m_resp", m_resp, 3'b010);
      check("t6_m_rdata", m_rdata, 32'hdead_beef);
      next_cycle();
      m_req = '0;
      @(negedge clk);
      check("t6_timeout_sticky", timeout, 1'b1);
      check("t6_back_idle", dbg_state, 2'd0);
    end
`endif

    random_phase(2000);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
